// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: region select, MMIO word map, default RAM depth.
package dmem_pkg;

   localparam int unsigned DEPTH_LOG2_DEF = 12;
   localparam int unsigned ADDR_W         = 17;
   localparam int unsigned DATA_W         = 32;
   localparam int unsigned REGION_BIT     = 16;

   localparam logic [ADDR_W-1:0] ADDR_BTN      = 17'h10000;
   localparam logic [ADDR_W-1:0] ADDR_BTN_EDGE = 17'h10001;
   localparam logic [ADDR_W-1:0] ADDR_SCORE    = 17'h10002;
   localparam logic [ADDR_W-1:0] ADDR_TICK     = 17'h10003;

   typedef enum logic [1:0] {
      REG_BTN      = 2'd0,
      REG_BTN_EDGE = 2'd1,
      REG_SCORE    = 2'd2,
      REG_TICK     = 2'd3
   } mmio_reg_e;

   // True when the address falls on one of the four mapped MMIO words.
   function automatic logic mmio_mapped(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:2] == ADDR_BTN[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage data bus: word address, store data, write enable and registered read data.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic [ADDR_W-1:0] address_dmem;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic [DATA_W-1:0] q_dmem;

   modport master (output address_dmem, data, wren, input q_dmem);
   modport slave  (input address_dmem, data, wren, output q_dmem);

endinterface

// File: rtl/dmem_responder_btn_sync.sv
// Button 2-flop synchronizer plus rising-edge detector on the synchronized level.
module btn_sync #(
   parameter int unsigned BTN_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [BTN_W-1:0] btn_in,
   output logic [BTN_W-1:0] level,
   output logic [BTN_W-1:0] rise
);

   logic [BTN_W-1:0] stage1;
   logic [BTN_W-1:0] stage2;
   logic [BTN_W-1:0] prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         stage1 <= '0;
         stage2 <= '0;
         prev   <= '0;
      end else begin
         stage1 <= btn_in;
         stage2 <= stage1;
         prev   <= stage2;
      end
   end

   assign level = stage2;
   assign rise  = stage2 & ~prev;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM with aliasing, plus optional MMIO window (BTN, BTN_EDGE, SCORE, TICK)
// enabled by defining DMEM_MMIO_EN; without it every address maps to RAM.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int unsigned BTN_W      = 4
) (
   input  logic                clock,
   input  logic                reset,
   dmem_responder_if.slave     bus,
   input  logic [BTN_W-1:0]    btn_in,
   output logic [DATA_W-1:0]   score_out
);

   logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic                  ram_sel;
   logic [DATA_W-1:0]     mmio_rdata;

   assign ram_idx = bus.address_dmem[DEPTH_LOG2-1:0];

`ifdef DMEM_MMIO_EN
   logic [BTN_W-1:0]  btn_level;
   logic [BTN_W-1:0]  btn_rise;
   logic [BTN_W-1:0]  btn_edge;
   logic [DATA_W-1:0] score;
   logic [DATA_W-1:0] tick;
   logic              mmio_hit;
   logic              edge_clr;
   mmio_reg_e         reg_sel;

   btn_sync #(.BTN_W(BTN_W)) u_btn_sync (
      .clock  (clock),
      .reset  (reset),
      .btn_in (btn_in),
      .level  (btn_level),
      .rise   (btn_rise)
   );

   assign ram_sel  = ~bus.address_dmem[REGION_BIT];
   assign mmio_hit = bus.address_dmem[REGION_BIT] && mmio_mapped(bus.address_dmem);
   assign reg_sel  = mmio_reg_e'(bus.address_dmem[1:0]);
   assign edge_clr = mmio_hit && !bus.wren && (reg_sel == REG_BTN_EDGE);

   always_comb begin
      mmio_rdata = '0;
      if (mmio_hit) begin
         case (reg_sel)
            REG_BTN:      mmio_rdata = DATA_W'(btn_level);
            REG_BTN_EDGE: mmio_rdata = DATA_W'(btn_edge);
            REG_SCORE:    mmio_rdata = score;
            REG_TICK:     mmio_rdata = tick;
            default:      mmio_rdata = '0;
         endcase
      end
   end

   // Clear is applied before OR-ing in new rises so a coincident edge survives the read.
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_edge <= '0;
         score    <= '0;
         tick     <= '0;
      end else begin
         tick     <= tick + 1'b1;
         btn_edge <= (btn_edge & ~{BTN_W{edge_clr}}) | btn_rise;
         if (mmio_hit && bus.wren && (reg_sel == REG_SCORE))
            score <= bus.data;
      end
   end

   assign score_out = score;
`else
   logic unused_inputs;

   assign ram_sel       = 1'b1;
   assign mmio_rdata    = '0;
   assign score_out     = '0;
   assign unused_inputs = ^{bus.address_dmem[ADDR_W-1:DEPTH_LOG2], btn_in};
`endif

   // RAM is deliberately not reset so contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (!reset && bus.wren && ram_sel)
         mem[ram_idx] <= bus.data;
   end

   always_ff @(posedge clock) begin
      if (reset)
         bus.q_dmem <= '0;
      else if (ram_sel)
         bus.q_dmem <= mem[ram_idx];
      else
         bus.q_dmem <= mmio_rdata;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven RAM vectors plus hand sequences for MMIO and reset.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  btn_in;
   logic [31:0] score_out;

   dmem_responder_if bus();

   dmem_responder #(.DEPTH_LOG2(12), .BTN_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .btn_in    (btn_in),
      .score_out (score_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [16:0] addr;
      logic [31:0] data;
      logic        wr;
      bit          chk;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[$];
   string       sb_name[$];
   logic [31:0] sb_exp[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   // Drive one bus cycle; an expected read result is queued and compared once the edge has passed.
   task automatic step(input logic [16:0] a, input logic [31:0] d, input logic w,
                       input bit chk, input logic [31:0] exp, input string nm);
      string       e_name;
      logic [31:0] e_exp;
      bus.address_dmem = a;
      bus.data         = d;
      bus.wren         = w;
      if (chk) begin
         sb_name.push_back(nm);
         sb_exp.push_back(exp);
      end
      @(posedge clock);
      #1;
      if (sb_exp.size() != 0) begin
         e_name = sb_name.pop_front();
         e_exp  = sb_exp.pop_front();
         check(e_name, bus.q_dmem, e_exp);
      end
   endtask

   task automatic add_vec(input logic [16:0] a, input logic [31:0] d, input logic w,
                          input bit chk, input logic [31:0] exp);
      vec_t v;
      v.addr = a;
      v.data = d;
      v.wr   = w;
      v.chk  = chk;
      v.exp  = exp;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1);
   end

   initial begin
      btn_in           = '0;
      reset            = 1'b1;
      bus.address_dmem = '0;
      bus.data         = '0;
      bus.wren         = 1'b0;

      step(17'h00000, 32'h0, 1'b0, 1'b1, 32'h0, "reset_q0");
      step(17'h00000, 32'h0, 1'b0, 1'b1, 32'h0, "reset_q1");
      check("reset_score", score_out, 32'h0);
      reset = 1'b0;

      add_vec(17'h00010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
      add_vec(17'h00010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
      add_vec(17'h01010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
      add_vec(17'h00030, 32'h3,        1'b1, 1'b0, 32'h0);
      add_vec(17'h00030, 32'h5,        1'b1, 1'b1, 32'h3);
      add_vec(17'h00030, 32'h0,        1'b0, 1'b1, 32'h5);
      add_vec(17'h00FFF, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0);
      add_vec(17'h00FFF, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5);
      add_vec(17'h0FFFF, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5);
      add_vec(17'h00000, 32'h1,        1'b1, 1'b0, 32'h0);
      add_vec(17'h00000, 32'h0,        1'b0, 1'b1, 32'h1);
      add_vec(17'h00010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].chk, vecs[i].exp,
              $sformatf("vec%0d", i));

`ifdef DMEM_MMIO_EN
      // SCORE read/write, read-only BTN, unmapped window.
      step(17'h10002, 32'h64, 1'b1, 1'b0, 32'h0, "");
      check("score_out_wr", score_out, 32'h64);
      step(17'h10002, 32'h0, 1'b0, 1'b1, 32'h64, "score_rd");
      step(17'h10000, 32'h1, 1'b1, 1'b0, 32'h0, "");
      step(17'h10000, 32'h0, 1'b0, 1'b1, 32'h0, "btn_ro");
      step(17'h10010, 32'h0, 1'b0, 1'b1, 32'h0, "unmapped_10010");
      step(17'h1FFFF, 32'h0, 1'b0, 1'b1, 32'h0, "unmapped_1ffff");

      // btn_in[2] rises: level visible from third edge, edge latch cleared by read.
      btn_in = 4'b0100;
      step(17'h10000, 32'h0, 1'b0, 1'b1, 32'h0, "btn_e1");
      step(17'h10000, 32'h0, 1'b0, 1'b1, 32'h0, "btn_e2");
      step(17'h10000, 32'h0, 1'b0, 1'b1, 32'h4, "btn_e3");
      step(17'h10001, 32'h0, 1'b0, 1'b1, 32'h4, "edge_rd");
      step(17'h10001, 32'h0, 1'b0, 1'b1, 32'h0, "edge_reread");

      // btn_in[0] rises; a write to BTN_EDGE must neither clear nor set.
      btn_in = 4'b0101;
      step(17'h00000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      step(17'h00000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      step(17'h00000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      step(17'h10001, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, "");
      step(17'h10001, 32'h0, 1'b0, 1'b1, 32'h1, "edge_wr_ignored");
      step(17'h10001, 32'h0, 1'b0, 1'b1, 32'h0, "edge_clr0");

      // btn_in[1] rise lands on the same edge as a clearing read.
      btn_in = 4'b0111;
      step(17'h00000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      step(17'h00000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      step(17'h10001, 32'h0, 1'b0, 1'b1, 32'h0, "edge_coinc_rd");
      step(17'h10001, 32'h0, 1'b0, 1'b1, 32'h2, "edge_coinc_kept");
      step(17'h10001, 32'h0, 1'b0, 1'b1, 32'h0, "edge_coinc_clr");
      step(17'h10000, 32'h0, 1'b0, 1'b1, 32'h7, "btn_level7");
`endif

      // Reset pulse mid-operation with wren held.
      step(17'h00020, 32'h7, 1'b1, 1'b0, 32'h0, "");
      reset = 1'b1;
      step(17'h00020, 32'h0,   1'b0, 1'b1, 32'h0, "rst_inflight");
      step(17'h00020, 32'hBAD, 1'b1, 1'b1, 32'h0, "rst_wr_ram");
      step(17'h10002, 32'h55,  1'b1, 1'b1, 32'h0, "rst_wr_score");
      check("rst_score_out", score_out, 32'h0);
      reset = 1'b0;
`ifdef DMEM_MMIO_EN
      step(17'h10003, 32'h0, 1'b0, 1'b1, 32'h0, "tick_first");
      step(17'h10003, 32'h0, 1'b0, 1'b1, 32'h1, "tick_second");
      step(17'h10002, 32'h0, 1'b0, 1'b1, 32'h0, "score_after_rst");
`endif
      step(17'h00020, 32'h0, 1'b0, 1'b1, 32'h7, "ram_kept");
      check("post_rst_score_out", score_out, 32'h0);

`ifndef DMEM_MMIO_EN
      // Without the MMIO window, 0x10002 is plain RAM word 2.
      step(17'h10002, 32'h9, 1'b1, 1'b0, 32'h0, "");
      step(17'h00002, 32'h0, 1'b0, 1'b1, 32'h9, "nommio_alias");
      check("nommio_score_out", score_out, 32'h0);
      btn_in = 4'hF;
      step(17'h10000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      step(17'h10000, 32'h0, 1'b0, 1'b0, 32'h0, "");
      step(17'h10000, 32'h0, 1'b0, 1'b1, 32'h1, "nommio_btn_ram");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, log2 of the RAM word count (4096 words).
REQ-002 SHALL have parameter BTN_W, default 4, width of the button input.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port address_dmem  in  17  word address from the memory stage.
REQ-006 SHALL have port data  in  32  store data.
REQ-007 SHALL have port wren  in  1  write enable; one store per asserted cycle.
REQ-008 SHALL have port q_dmem  out  32  registered read data.
REQ-009 SHALL have port btn_in  in  BTN_W  asynchronous button levels.
REQ-010 SHALL have port score_out  out  32  current SCORE register value.

Function
REQ-011 SHALL decode the region by address_dmem[16]: 0 selects RAM, 1 selects the MMIO window.
REQ-012 SHALL index RAM with address_dmem[DEPTH_LOG2-1:0]; bits DEPTH_LOG2..15 are ignored, so RAM aliases.
REQ-013 SHALL write data to the selected RAM word at the clock edge where wren=1 and reset=0.
REQ-014 SHALL register q_dmem with one-cycle latency: the value at edge N reflects address_dmem sampled at edge N.
REQ-015 SHALL use read-first behaviour: a read and write to the same word at one edge returns the old contents.
REQ-016 SHALL decode MMIO word 0x10000 BTN as read-only and return the synchronized btn_in, zero-extended.
REQ-017 SHALL decode MMIO word 0x10001 BTN_EDGE as a sticky per-bit rising-edge latch that is cleared when read.
REQ-018 SHALL keep a BTN_EDGE bit set when its new edge coincides with a clearing read; the new event wins.
REQ-019 SHALL decode MMIO word 0x10002 SCORE as read/write and drive score_out directly from it.
REQ-020 SHALL decode MMIO word 0x10003 TICK as a free-running 32-bit cycle counter, read-only, wrapping 0xFFFFFFFF->0.
REQ-021 SHALL ignore writes to read-only MMIO words and return 0 for unmapped MMIO addresses 0x10004-0x1FFFF.
REQ-022 SHALL pass btn_in through a 2-flop synchronizer; edge detection uses synchronized current vs previous level.
REQ-023 SHALL apply a clear-on-read only on a cycle with wren=0; a write to BTN_EDGE neither clears nor sets it.

Reset
REQ-024 SHALL, while reset=1, drive q_dmem=0, SCORE=0, TICK=0, BTN_EDGE=0 and both synchronizer stages=0.
REQ-025 SHALL suppress RAM and MMIO writes while reset=1; RAM contents are preserved, not cleared.
REQ-026 SHALL, on reset asserted mid-operation, discard any in-flight read; the first valid read is one cycle after release.

Configuration
REQ-027 SHALL, with DMEM_MMIO_EN defined, implement the MMIO window, synchronizer, TICK and SCORE as specified.
REQ-028 SHALL, without DMEM_MMIO_EN, ignore address_dmem[16] so all addresses map to RAM, leave btn_in unused, and tie score_out to 0.

Structure
REQ-029 SHALL take the MMIO word addresses, region-select bit index and DEPTH_LOG2 default from shared package dmem_pkg.
REQ-030 SHALL place the synchronizer and edge detector in sub-module btn_sync (ports clock, reset, btn_in, level, rise).

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to 0x00010 -> read 0x00010 gives 0xDEADBEEF one cycle later; read 0x01010 (alias, DEPTH_LOG2=12) also gives 0xDEADBEEF.
REQ-032 SHALL cover: same-cycle write 0x5 and read of a word holding 0x3 -> q_dmem=0x3, next read=0x5.
REQ-033 SHALL cover: btn_in[2] 0->1 -> BTN reads 0x4 from the third edge; BTN_EDGE reads 0x4, then 0x0 on re-read.
REQ-034 SHALL cover: write 0x64 to 0x10002 -> score_out=0x64 next cycle; write 0x1 to 0x10000 -> BTN unchanged; read 0x10010 -> 0.
REQ-035 SHALL cover: reset pulse after SCORE=0x64 and RAM[0x20]=0x7 -> score_out=0, TICK restarts at 0, RAM[0x20] still 0x7; wren held during reset writes nothing.
REQ-036 SHALL cover: with DMEM_MMIO_EN undefined, write 0x9 to 0x10002 -> read 0x00002 returns 0x9 and score_out stays 0.
